// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stack_pkg
// Brief   : Shared constants and helpers for the LIFO stack: operation
//           encoding and a constant-foldable ceiling-log2.
// Revision: 1.0 - initial release
// ============================================================================
package stack_pkg;

    // Decoded request encoding, {pop, push}
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

    // Ceiling log2; clog2(1) = 0. Bounded loop so it folds at elaboration.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge_sync.sv
`default_nettype none
// ============================================================================
// Module  : btn_edge_sync
// Brief   : Two-flop synchroniser for a raw asynchronous button followed by a
//           rising-edge detector; emits a single-cycle pulse per press.
// Revision: 1.0 - initial release
// ============================================================================
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronise the button and keep one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Pulse is high for the one cycle after the synchronised level rises,
    // so a press first sampled at edge k acts at edge k+2.
    assign o_pulse = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/lifo_stack_param.sv
`default_nettype none
// ============================================================================
// Module  : lifo_stack_param
// Brief   : Parametrised LIFO stack with replace-top, occupancy count, sticky
//           overflow/underflow and optional button one-shot front end.
//           dout is a registered copy of the top of stack (0 when empty).
// Revision: 1.0 - initial release
// ============================================================================
module lifo_stack_param
    import stack_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int DEPTH   = 8,
    parameter  int ONESHOT = 1,
    localparam int CW      = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             push_btn,
    input  logic             pop_btn,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int          c_aw       = clog2(DEPTH);
    localparam logic [CW-1:0] c_full_cnt = CW'(DEPTH);

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_op;
    logic             w_empty;
    logic             w_full;

    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_dout_nxt;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             w_we;
    logic [c_aw-1:0]  w_wr_idx;

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Request front end: one-shot buttons or direct level strobes
    generate
        if (ONESHOT != 0) begin : g_oneshot
            btn_edge_sync u_push_sync (
                .clk     (clk),
                .reset   (reset),
                .i_btn   (push_btn),
                .o_pulse (w_push)
            );
            btn_edge_sync u_pop_sync (
                .clk     (clk),
                .reset   (reset),
                .i_btn   (pop_btn),
                .o_pulse (w_pop)
            );
        end else begin : g_level
            assign w_push = push_btn;
            assign w_pop  = pop_btn;
        end
    endgenerate

    assign w_op    = {w_pop, w_push};
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_cnt);

    // Next-state decode; every range test is on the full-width count and
    // only in-range values are narrowed to an array index.
    always_comb begin
        w_count_nxt = r_count;
        w_dout_nxt  = r_dout;
        w_we        = 1'b0;
        w_wr_idx    = '0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        unique case (w_op)
            OP_PUSH: begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_we        = 1'b1;
                    w_wr_idx    = c_aw'(r_count);
                    w_count_nxt = r_count + CW'(1);
                    w_dout_nxt  = din;
                end
            end
            OP_POP: begin
                if (w_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_count_nxt = r_count - CW'(1);
                    if (r_count >= CW'(2)) begin
                        w_dout_nxt = r_mem[c_aw'(r_count - CW'(2))];
                    end else begin
                        w_dout_nxt = '0;
                    end
                end
            end
            OP_REPL: begin
                // Replace-top on an empty stack degenerates to a plain push
                w_we       = 1'b1;
                w_dout_nxt = din;
                if (w_empty) begin
                    w_wr_idx    = '0;
                    w_count_nxt = CW'(1);
                end else begin
                    w_wr_idx = c_aw'(r_count - CW'(1));
                end
            end
            OP_NONE: begin
            end
            default: begin
            end
        endcase
    end

    // Occupancy and registered top-of-stack word
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_dout  <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

    // Sticky error flags; a fresh error at the clearing edge keeps the flag set
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  & ~err_clr) | w_ovf_set;
            r_underflow <= (r_underflow & ~err_clr) | w_unf_set;
        end
    end

    // Storage array: single write port, contents survive reset
    always_ff @(posedge clk) begin
        if (reset && w_we) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    assign dout      = r_dout;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_lifo_stack_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_lifo_stack_param
// Brief   : Self-checking bench: directed scenarios plus random traffic, all
//           compared against a queue-based stack model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lifo_stack_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH 8, DEPTH 4, level strobes
    logic       reset_a, push_a, pop_a, clr_a;
    logic [7:0] din_a, dout_a;
    logic [2:0] count_a;
    logic       empty_a, full_a, ovf_a, unf_a;

    // Instance B: WIDTH 8, DEPTH 4, one-shot buttons
    logic       reset_b, push_b, pop_b, clr_b;
    logic [7:0] din_b, dout_b;
    logic [2:0] count_b;
    logic       empty_b, full_b, ovf_b, unf_b;

    // Instance C: WIDTH 12, DEPTH 5, level strobes
    logic        reset_c, push_c, pop_c, clr_c;
    logic [11:0] din_c, dout_c;
    logic [2:0]  count_c;
    logic        empty_c, full_c, ovf_c, unf_c;

    lifo_stack_param #(.WIDTH(8), .DEPTH(4), .ONESHOT(0)) u_dut_a (
        .clk(clk), .reset(reset_a), .din(din_a), .push_btn(push_a), .pop_btn(pop_a),
        .err_clr(clr_a), .dout(dout_a), .count(count_a), .empty(empty_a), .full(full_a),
        .overflow(ovf_a), .underflow(unf_a)
    );

    lifo_stack_param #(.WIDTH(8), .DEPTH(4), .ONESHOT(1)) u_dut_b (
        .clk(clk), .reset(reset_b), .din(din_b), .push_btn(push_b), .pop_btn(pop_b),
        .err_clr(clr_b), .dout(dout_b), .count(count_b), .empty(empty_b), .full(full_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    lifo_stack_param #(.WIDTH(12), .DEPTH(5), .ONESHOT(0)) u_dut_c (
        .clk(clk), .reset(reset_c), .din(din_c), .push_btn(push_c), .pop_btn(pop_c),
        .err_clr(clr_c), .dout(dout_c), .count(count_c), .empty(empty_c), .full(full_c),
        .overflow(ovf_c), .underflow(unf_c)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference stacks: the queue tail is the top of stack
    logic [7:0]  qa[$];
    logic        ova = 1'b0, una = 1'b0;
    logic [11:0] qc[$];
    logic        ovc = 1'b0, unc = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock on instance A: drive, update model at the edge, check at negedge
    task automatic step_a(input logic rst_n, input logic push, input logic pop,
                          input logic clr, input logic [7:0] d);
        logic o_set, u_set;
        reset_a = rst_n; push_a = push; pop_a = pop; clr_a = clr; din_a = d;
        @(posedge clk);
        o_set = 1'b0; u_set = 1'b0;
        if (!rst_n) begin
            qa.delete(); ova = 1'b0; una = 1'b0;
        end else begin
            if (push && (!pop || qa.size() == 0)) begin
                if (qa.size() < 4) qa.push_back(d); else o_set = 1'b1;
            end else if (pop && !push) begin
                if (qa.size() > 0) void'(qa.pop_back()); else u_set = 1'b1;
            end else if (push && pop) begin
                qa[qa.size() - 1] = d;
            end
            ova = (ova & ~clr) | o_set;
            una = (una & ~clr) | u_set;
        end
        @(negedge clk);
        check_val("a_count", 32'(count_a), 32'(qa.size()));
        check_val("a_dout", 32'(dout_a), (qa.size() != 0) ? 32'(qa[qa.size() - 1]) : 32'd0);
        check_val("a_empty", 32'(empty_a), 32'(qa.size() == 0));
        check_val("a_full", 32'(full_a), 32'(qa.size() == 4));
        check_val("a_ovf", 32'(ovf_a), 32'(ova));
        check_val("a_unf", 32'(unf_a), 32'(una));
    endtask

    // One clock on instance C with its own DEPTH-5 model
    task automatic step_c(input logic rst_n, input logic push, input logic pop,
                          input logic clr, input logic [11:0] d);
        logic o_set, u_set;
        reset_c = rst_n; push_c = push; pop_c = pop; clr_c = clr; din_c = d;
        @(posedge clk);
        o_set = 1'b0; u_set = 1'b0;
        if (!rst_n) begin
            qc.delete(); ovc = 1'b0; unc = 1'b0;
        end else begin
            if (push && (!pop || qc.size() == 0)) begin
                if (qc.size() < 5) qc.push_back(d); else o_set = 1'b1;
            end else if (pop && !push) begin
                if (qc.size() > 0) void'(qc.pop_back()); else u_set = 1'b1;
            end else if (push && pop) begin
                qc[qc.size() - 1] = d;
            end
            ovc = (ovc & ~clr) | o_set;
            unc = (unc & ~clr) | u_set;
        end
        @(negedge clk);
        check_val("c_count", 32'(count_c), 32'(qc.size()));
        check_val("c_dout", 32'(dout_c), (qc.size() != 0) ? 32'(qc[qc.size() - 1]) : 32'd0);
        check_val("c_empty", 32'(empty_c), 32'(qc.size() == 0));
        check_val("c_full", 32'(full_c), 32'(qc.size() == 5));
        check_val("c_ovf", 32'(ovf_c), 32'(ovc));
        check_val("c_unf", 32'(unf_c), 32'(unc));
    endtask

    initial begin
        reset_a = 1'b0; push_a = 1'b0; pop_a = 1'b0; clr_a = 1'b0; din_a = '0;
        reset_b = 1'b0; push_b = 1'b0; pop_b = 1'b0; clr_b = 1'b0; din_b = '0;
        reset_c = 1'b0; push_c = 1'b0; pop_c = 1'b0; clr_c = 1'b0; din_c = '0;

        // Reset state
        step_a(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step_a(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step_a(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check_val("t1_count", 32'(count_a), 32'd0);
        check_val("t1_empty", 32'(empty_a), 32'd1);
        check_val("t1_dout", 32'(dout_a), 32'h00);

        // Fill to full, then overflow
        step_a(1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
        step_a(1'b1, 1'b1, 1'b0, 1'b0, 8'h22);
        step_a(1'b1, 1'b1, 1'b0, 1'b0, 8'h33);
        step_a(1'b1, 1'b1, 1'b0, 1'b0, 8'h44);
        check_val("t2_full", 32'(full_a), 32'd1);
        step_a(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        check_val("t2_ovf", 32'(ovf_a), 32'd1);
        check_val("t2_dout", 32'(dout_a), 32'h44);
        check_val("t2_count", 32'(count_a), 32'd4);

        // Drain, underflow, clear flags
        step_a(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check_val("t3_pop1", 32'(dout_a), 32'h33);
        step_a(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step_a(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check_val("t3_pop3", 32'(dout_a), 32'h11);
        step_a(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check_val("t3_pop4", 32'(dout_a), 32'h00);
        step_a(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check_val("t3_unf", 32'(unf_a), 32'd1);
        step_a(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        check_val("t3_clr", 32'({ovf_a, unf_a}), 32'd0);

        // Replace-top, and push+pop on empty
        step_a(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
        step_a(1'b1, 1'b1, 1'b1, 1'b0, 8'hBB);
        check_val("t4_repl", 32'({count_a, dout_a}), 32'({3'd1, 8'hBB}));
        step_a(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check_val("t4_pop", 32'({empty_a, dout_a}), 32'({1'b1, 8'h00}));
        step_a(1'b1, 1'b1, 1'b1, 1'b0, 8'hCC);
        check_val("t4_pp_empty", 32'({count_a, dout_a}), 32'({3'd1, 8'hCC}));

        // Error arriving on the clearing edge wins
        step_a(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step_a(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        check_val("t4_err_wins", 32'(unf_a), 32'd1);

        // One-shot: a long press gives exactly one push, two edges after first sample
        @(negedge clk); reset_b = 1'b0;
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        repeat (3) @(negedge clk);
        check_val("t5_idle", 32'(count_b), 32'd0);
        push_b = 1'b1; din_b = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        check_val("t5_k", 32'(count_b), 32'd0);
        @(negedge clk);
        check_val("t5_k1", 32'(count_b), 32'd0);
        @(negedge clk);
        check_val("t5_k2_cnt", 32'(count_b), 32'd1);
        check_val("t5_k2_dout", 32'(dout_b), 32'h5A);
        repeat (7) @(negedge clk);
        check_val("t5_held", 32'(count_b), 32'd1);
        push_b = 1'b0;
        repeat (4) @(negedge clk);
        push_b = 1'b1; din_b = 8'h6B;
        repeat (5) @(negedge clk);
        check_val("t5_second", 32'({count_b, dout_b}), 32'({3'd2, 8'h6B}));
        push_b = 1'b0;
        pop_b = 1'b1;
        repeat (6) @(negedge clk);
        check_val("t5_pop", 32'({count_b, dout_b}), 32'({3'd1, 8'h5A}));
        pop_b = 1'b0;

        // DEPTH 5 / WIDTH 12: overflow and reset in mid pop sequence
        step_c(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        step_c(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
        for (int i = 0; i < 6; i++) step_c(1'b1, 1'b1, 1'b0, 1'b0, 12'($urandom));
        check_val("t6_count", 32'(count_c), 32'd5);
        check_val("t6_ovf", 32'(ovf_c), 32'd1);
        step_c(1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
        step_c(1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
        step_c(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        check_val("t6_rst", 32'({count_c, dout_c}), 32'd0);

        // Random traffic on both level-mode instances
        for (int i = 0; i < 300; i++) begin
            step_a(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0), 8'($urandom));
        end
        for (int i = 0; i < 200; i++) begin
            step_c(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                   ($urandom_range(0, 99) < 55), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0), 12'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
